// File: rtl/tim6_cnt_core.sv
// Timer 6 time-base: prescaler, up-counter and registered update-event stage.
// Optional DMA request output is built when TIM6_DMA_EN is defined.
module tim6_cnt_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             arpe,
    input  logic             opm,
    input  logic             udis,
    input  logic             urs,
    input  logic             ug,
    input  logic             uif_clr,
`ifdef TIM6_DMA_EN
    input  logic             ude,
`endif
    input  logic [WIDTH-1:0] psc_breg,
    input  logic [WIDTH-1:0] arr_breg,
    input  logic [WIDTH-1:0] arr_sh,
    output logic [WIDTH-1:0] cnt,
    output logic             ld_sh_reg,
    output logic             uev,
    output logic             uif,
`ifdef TIM6_DMA_EN
    output logic             dma_req,
`endif
    output logic             cen_clr
);

    logic [WIDTH-1:0] psc_cnt;
    logic [WIDTH-1:0] psc_sh;
    logic [WIDTH-1:0] arr_eff;
    logic             tick;
    logic             ovf;
    logic             uev_src;
    logic             uif_set;

    assign arr_eff = arpe ? arr_sh : arr_breg;
    assign tick    = cen && (psc_cnt == psc_sh);
    assign ovf     = tick && (cnt == arr_eff);
    assign uev_src = !udis && (ovf || ug);
    // A ug-only event does not flag the interrupt when urs restricts it to overflow.
    assign uif_set = !udis && (ovf || (ug && !urs));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            psc_cnt <= '0;
            psc_sh  <= '0;
        end else begin
            if (ug) begin
                cnt     <= '0;
                psc_cnt <= '0;
            end else if (tick) begin
                psc_cnt <= '0;
                cnt     <= (cnt == arr_eff) ? '0 : cnt + 1'b1;
            end else if (cen) begin
                psc_cnt <= psc_cnt + 1'b1;
            end
            if (uev_src) begin
                psc_sh <= psc_breg;
            end
        end
    end

    // Event outputs are plain flops; ld_sh_reg clocks the shadow register downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uev       <= 1'b0;
            ld_sh_reg <= 1'b0;
            cen_clr   <= 1'b0;
            uif       <= 1'b0;
        end else begin
            uev       <= uev_src;
            ld_sh_reg <= uev_src;
            cen_clr   <= opm && !udis && ovf;
            if (uif_set) begin
                uif <= 1'b1;
            end else if (uif_clr) begin
                uif <= 1'b0;
            end
        end
    end

`ifdef TIM6_DMA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_req <= 1'b0;
        end else begin
            dma_req <= ude && uif_set;
        end
    end
`endif

endmodule
